// File: rtl/ddr3_app_arbiter.sv
// Arbitrates the write-request and read-request FIFOs onto the DDR3 MIG app
// interface, with burst fairness and an outstanding-read throttle.
module ddr3_app_arbiter #(
    parameter int ADDRESS_WIDTH   = 32,
    parameter int DATA_WIDTH      = 128,
    parameter int MAX_OUTSTANDING = 8,
    parameter int BURST_LIMIT     = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      en,
    input  logic                      wr_fifo_empty,
    input  logic [ADDRESS_WIDTH-1:0]  wr_fifo_address,
    input  logic [DATA_WIDTH-1:0]     wr_fifo_data,
    output logic                      wr_fifo_read,
    input  logic                      rd_fifo_empty,
    input  logic [ADDRESS_WIDTH-1:0]  rd_fifo_address,
    output logic                      rd_fifo_read,
    input  logic                      rd_out_full,
    output logic [28:0]               app_addr,
    output logic [2:0]                app_cmd,
    output logic                      app_en,
    input  logic                      app_rdy,
    output logic [DATA_WIDTH-1:0]     app_wdf_data,
    output logic                      app_wdf_wren,
    output logic                      app_wdf_end,
    output logic [DATA_WIDTH/8-1:0]   app_wdf_mask,
    input  logic                      app_wdf_rdy,
    input  logic                      app_rd_data_valid,
    output logic [7:0]                outstanding,
    output logic                      busy,
    output logic                      err_underflow
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_CMD  = 2'd1,
        WR_DATA = 2'd2,
        WR_CMD  = 2'd3
    } state_t;

    localparam int            SW         = $clog2(BURST_LIMIT + 1);
    localparam logic [SW-1:0] STREAK_MAX = SW'(BURST_LIMIT);
    localparam logic [7:0]    OUT_MAX    = 8'(MAX_OUTSTANDING);

    state_t                  state_r;
    logic                    last_rd_r;
    logic [SW-1:0]           streak_r;
    logic [7:0]              outstanding_r;
    logic                    err_underflow_r;
    logic                    app_en_r;
    logic [2:0]              app_cmd_r;
    logic [28:0]             app_addr_r;
    logic [DATA_WIDTH-1:0]   wdf_data_r;
    logic                    wdf_wren_r;

    logic rd_elig_s;
    logic wr_elig_s;
    logic grant_rd_s;
    logic grant_wr_s;
    logic grant_same_s;
    logic rd_accept_s;
    logic wr_accept_s;
    logic unused_addr_s;

    assign unused_addr_s = ^{rd_fifo_address[ADDRESS_WIDTH-1:29], wr_fifo_address[ADDRESS_WIDTH-1:29]};

    // eligibility and grant selection; a streak at the limit hands over to the other side
    always_comb begin
        rd_elig_s    = !rd_fifo_empty && (outstanding_r < OUT_MAX) && !rd_out_full;
        wr_elig_s    = !wr_fifo_empty;
        grant_rd_s   = 1'b0;
        grant_wr_s   = 1'b0;
        if (en && (state_r == IDLE)) begin
            if (rd_elig_s && wr_elig_s) begin
                if (streak_r < STREAK_MAX) begin
                    grant_rd_s = last_rd_r;
                    grant_wr_s = !last_rd_r;
                end else begin
                    grant_rd_s = !last_rd_r;
                    grant_wr_s = last_rd_r;
                end
            end else begin
                grant_rd_s = rd_elig_s;
                grant_wr_s = wr_elig_s;
            end
        end else begin
            grant_rd_s = 1'b0;
            grant_wr_s = 1'b0;
        end
        grant_same_s = grant_rd_s ? last_rd_r : !last_rd_r;
    end

    assign rd_accept_s  = (state_r == RD_CMD) && app_en_r && app_rdy;
    assign wr_accept_s  = (state_r == WR_CMD) && app_en_r && app_rdy;
    assign rd_fifo_read = rd_accept_s;
    assign wr_fifo_read = wr_accept_s;

    // command sequencer: grant, write-data beat, command handshake
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= IDLE;
            last_rd_r  <= 1'b1;
            streak_r   <= '0;
            app_en_r   <= 1'b0;
            app_cmd_r  <= 3'b000;
            app_addr_r <= 29'd0;
            wdf_data_r <= '0;
            wdf_wren_r <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (grant_rd_s) begin
                        state_r    <= RD_CMD;
                        app_en_r   <= 1'b1;
                        app_cmd_r  <= 3'b001;
                        app_addr_r <= rd_fifo_address[28:0];
                    end else if (grant_wr_s) begin
                        state_r    <= WR_DATA;
                        wdf_wren_r <= 1'b1;
                        wdf_data_r <= wr_fifo_data;
                        app_cmd_r  <= 3'b000;
                        app_addr_r <= wr_fifo_address[28:0];
                    end else begin
                        state_r <= IDLE;
                    end
                    if (grant_rd_s || grant_wr_s) begin
                        last_rd_r <= grant_rd_s;
                        if (!grant_same_s) begin
                            streak_r <= SW'(1);
                        end else if (streak_r < STREAK_MAX) begin
                            streak_r <= streak_r + SW'(1);
                        end else begin
                            streak_r <= streak_r;
                        end
                    end else begin
                        streak_r <= streak_r;
                    end
                end
                RD_CMD: begin
                    if (app_rdy) begin
                        app_en_r <= 1'b0;
                        state_r  <= IDLE;
                    end else begin
                        state_r  <= RD_CMD;
                    end
                end
                WR_DATA: begin
                    if (app_wdf_rdy) begin
                        wdf_wren_r <= 1'b0;
                        app_en_r   <= 1'b1;
                        state_r    <= WR_CMD;
                    end else begin
                        state_r    <= WR_DATA;
                    end
                end
                WR_CMD: begin
                    if (app_rdy) begin
                        app_en_r <= 1'b0;
                        state_r  <= IDLE;
                    end else begin
                        state_r  <= WR_CMD;
                    end
                end
                default: begin
                    state_r    <= IDLE;
                    app_en_r   <= 1'b0;
                    wdf_wren_r <= 1'b0;
                end
            endcase
        end
    end

    // outstanding read accounting; a return with nothing in flight is flagged and ignored
    always_ff @(posedge clk) begin
        if (rst) begin
            outstanding_r   <= 8'd0;
            err_underflow_r <= 1'b0;
        end else begin
            if (rd_accept_s && !app_rd_data_valid) begin
                outstanding_r <= outstanding_r + 8'd1;
            end else if (!rd_accept_s && app_rd_data_valid && (outstanding_r != 8'd0)) begin
                outstanding_r <= outstanding_r - 8'd1;
            end else begin
                outstanding_r <= outstanding_r;
            end
            if (app_rd_data_valid && (outstanding_r == 8'd0)) begin
                err_underflow_r <= 1'b1;
            end else begin
                err_underflow_r <= err_underflow_r;
            end
        end
    end

    assign app_en        = app_en_r;
    assign app_cmd       = app_cmd_r;
    assign app_addr      = app_addr_r;
    assign app_wdf_data  = wdf_data_r;
    assign app_wdf_wren  = wdf_wren_r;
    assign app_wdf_end   = wdf_wren_r;
    assign app_wdf_mask  = '0;
    assign outstanding   = outstanding_r;
    assign err_underflow = err_underflow_r;
    assign busy          = (state_r != IDLE) || (outstanding_r != 8'd0);

endmodule

// File: tb/tb_ddr3_app_arbiter.sv
// Self-checking bench for ddr3_app_arbiter: FIFO models feed the DUT, a scoreboard
// matches accepted MIG commands against the requests pushed.
module tb_ddr3_app_arbiter;

    localparam int AW   = 32;
    localparam int DW   = 128;
    localparam int MAXO = 2;
    localparam int BL   = 4;
    localparam logic [1:0] G_NONE = 2'd0;
    localparam logic [1:0] G_RD   = 2'd1;
    localparam logic [1:0] G_WR   = 2'd2;

    logic          clk = 1'b0;
    logic          rst;
    logic          en;
    logic          wr_fifo_empty;
    logic [AW-1:0] wr_fifo_address;
    logic [DW-1:0] wr_fifo_data;
    logic          wr_fifo_read;
    logic          rd_fifo_empty;
    logic [AW-1:0] rd_fifo_address;
    logic          rd_fifo_read;
    logic          rd_out_full;
    logic [28:0]   app_addr;
    logic [2:0]    app_cmd;
    logic          app_en;
    logic          app_rdy;
    logic [DW-1:0] app_wdf_data;
    logic          app_wdf_wren;
    logic          app_wdf_end;
    logic [15:0]   app_wdf_mask;
    logic          app_wdf_rdy;
    logic          app_rd_data_valid;
    logic [7:0]    outstanding;
    logic          busy;
    logic          err_underflow;

    always #5 clk = ~clk;

    ddr3_app_arbiter #(
        .ADDRESS_WIDTH  (AW),
        .DATA_WIDTH     (DW),
        .MAX_OUTSTANDING(MAXO),
        .BURST_LIMIT    (BL)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .en               (en),
        .wr_fifo_empty    (wr_fifo_empty),
        .wr_fifo_address  (wr_fifo_address),
        .wr_fifo_data     (wr_fifo_data),
        .wr_fifo_read     (wr_fifo_read),
        .rd_fifo_empty    (rd_fifo_empty),
        .rd_fifo_address  (rd_fifo_address),
        .rd_fifo_read     (rd_fifo_read),
        .rd_out_full      (rd_out_full),
        .app_addr         (app_addr),
        .app_cmd          (app_cmd),
        .app_en           (app_en),
        .app_rdy          (app_rdy),
        .app_wdf_data     (app_wdf_data),
        .app_wdf_wren     (app_wdf_wren),
        .app_wdf_end      (app_wdf_end),
        .app_wdf_mask     (app_wdf_mask),
        .app_wdf_rdy      (app_wdf_rdy),
        .app_rd_data_valid(app_rd_data_valid),
        .outstanding      (outstanding),
        .busy             (busy),
        .err_underflow    (err_underflow)
    );

    typedef struct {
        logic [28:0]   addr;
        logic [DW-1:0] data;
    } exp_wr_t;

    typedef struct {
        logic          en;
        logic          wr_ne;
        logic          rd_ne;
        logic          rd_full;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic [1:0]    exp_grant;
    } vec_t;

    // FIFO models and scoreboard queues
    logic [AW-1:0] rd_q[$];
    logic [AW-1:0] wa_q[$];
    logic [DW-1:0] wd_q[$];
    logic [28:0]   exp_rd_q[$];
    exp_wr_t       exp_wr_q[$];
    logic          glog[$];

    int n_chk = 0;
    int n_fail = 0;
    int n_rd_acc = 0;
    int n_wr_acc = 0;
    logic          pop_rd = 1'b0;
    logic          pop_wr = 1'b0;
    logic          rd_acc = 1'b0;
    logic          auto_ret = 1'b0;
    logic          hold_cmd = 1'b0;
    logic          hold_wdf = 1'b0;
    logic [31:0]   prev_cmdaddr = 32'd0;
    logic [DW-1:0] prev_wdata = '0;
    logic [DW-1:0] wcap = '0;
    vec_t          vecs[8];

    task automatic check(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic fail(input string nm, input string info);
        n_chk++;
        n_fail++;
        $display("FAIL %s: %s", nm, info);
    endtask

    task automatic refresh();
        rd_fifo_empty   = (rd_q.size() == 0);
        rd_fifo_address = rd_fifo_empty ? 32'd0 : rd_q[0];
        wr_fifo_empty   = (wa_q.size() == 0);
        wr_fifo_address = wr_fifo_empty ? 32'd0 : wa_q[0];
        wr_fifo_data    = wr_fifo_empty ? {DW{1'b0}} : wd_q[0];
    endtask

    task automatic push_rd(input logic [AW-1:0] a);
        rd_q.push_back(a);
        exp_rd_q.push_back(a[28:0]);
        refresh();
    endtask

    task automatic push_wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
        exp_wr_t e;
        wa_q.push_back(a);
        wd_q.push_back(d);
        e.addr = a[28:0];
        e.data = d;
        exp_wr_q.push_back(e);
        refresh();
    endtask

    // mid-cycle scoreboard: accepts, pops, handshake stability
    task automatic monitor();
        exp_wr_t e;
        rd_acc = 1'b0;
        pop_rd = rd_fifo_read;
        pop_wr = wr_fifo_read;
        if (app_wdf_wren) begin
            check("wdf_mask", app_wdf_mask, 16'd0);
            check("wdf_end", app_wdf_end, 1'b1);
            if (hold_wdf) check("wdf_data_stable", app_wdf_data, prev_wdata);
            if (app_wdf_rdy) wcap = app_wdf_data;
        end
        if (app_en && hold_cmd) check("cmd_stable", {app_cmd, app_addr}, prev_cmdaddr);
        if (app_en && app_rdy && (app_cmd == 3'b001)) begin
            n_rd_acc++;
            rd_acc = 1'b1;
            glog.push_back(1'b1);
            check("rd_pop", {rd_fifo_read, wr_fifo_read}, 2'b10);
            if (exp_rd_q.size() == 0) begin
                fail("rd_unexpected", $sformatf("read of %0h accepted with none pending", app_addr));
            end else begin
                check("rd_addr", app_addr, exp_rd_q[0]);
                exp_rd_q.delete(0);
            end
        end else if (app_en && app_rdy && (app_cmd == 3'b000)) begin
            n_wr_acc++;
            glog.push_back(1'b0);
            check("wr_pop", {rd_fifo_read, wr_fifo_read}, 2'b01);
            if (exp_wr_q.size() == 0) begin
                fail("wr_unexpected", $sformatf("write of %0h accepted with none pending", app_addr));
            end else begin
                e = exp_wr_q[0];
                exp_wr_q.delete(0);
                check("wr_addr", app_addr, e.addr);
                check("wr_data", wcap, e.data);
            end
        end else if (app_en && app_rdy) begin
            fail("bad_cmd", $sformatf("app_cmd=%0b", app_cmd));
        end else begin
            check("no_pop", {rd_fifo_read, wr_fifo_read}, 2'b00);
        end
        hold_cmd     = app_en && !app_rdy;
        prev_cmdaddr = {app_cmd, app_addr};
        hold_wdf     = app_wdf_wren && !app_wdf_rdy;
        prev_wdata   = app_wdf_data;
    endtask

    // one clock: check at negedge, then apply FIFO pops and auto read return after the edge
    task automatic tick();
        @(negedge clk);
        monitor();
        @(posedge clk);
        #1;
        if (pop_rd && (rd_q.size() > 0)) rd_q.delete(0);
        if (pop_wr && (wa_q.size() > 0)) begin
            wa_q.delete(0);
            wd_q.delete(0);
        end
        app_rd_data_valid = auto_ret && rd_acc;
        refresh();
    endtask

    task automatic wait_idle(input string nm);
        int n;
        n = 0;
        while (((rd_q.size() != 0) || (wa_q.size() != 0) || busy) && (n < 200)) begin
            tick();
            n++;
        end
        if (n >= 200) fail(nm, "timeout waiting for idle");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base_rd;
        int base_wr;
        int wc;
        int ec;
        int active;
        int cur;
        int runs[$];
        logic [1:0] obs;

        // grant decisions; history-dependent rows follow from the grants issued before them
        vecs[0] = '{1'b0, 1'b1, 1'b1, 1'b0, 32'hE000_1000, 128'h1111_0000_0000_0000_0000_0000_0000_0001, G_NONE};
        vecs[1] = '{1'b1, 1'b0, 1'b1, 1'b0, 32'hA000_1100, 128'h0, G_RD};
        vecs[2] = '{1'b1, 1'b0, 1'b1, 1'b1, 32'h0000_1200, 128'h0, G_NONE};
        vecs[3] = '{1'b1, 1'b1, 1'b0, 1'b0, 32'hF000_1300, 128'h3333_0000_0000_0000_0000_0000_0000_0003, G_WR};
        vecs[4] = '{1'b1, 1'b1, 1'b1, 1'b0, 32'h0000_1400, 128'h4444_0000_0000_0000_0000_0000_0000_0004, G_WR};
        vecs[5] = '{1'b1, 1'b1, 1'b1, 1'b0, 32'h2000_1500, 128'h5555_0000_0000_0000_0000_0000_0000_0005, G_RD};
        vecs[6] = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_1600, 128'h0, G_NONE};
        vecs[7] = '{1'b1, 1'b1, 1'b1, 1'b1, 32'h0000_1700, 128'h7777_0000_0000_0000_0000_0000_0000_0007, G_WR};

        rst = 1'b1;
        en = 1'b0;
        rd_out_full = 1'b0;
        app_rdy = 1'b0;
        app_wdf_rdy = 1'b0;
        app_rd_data_valid = 1'b0;
        refresh();
        tick();
        tick();
        check("reset_ctrl", {app_en, app_wdf_wren, app_wdf_end, app_cmd, outstanding, busy,
                             err_underflow, rd_fifo_read, wr_fifo_read, app_wdf_mask}, 34'd0);
        check("reset_addr", app_addr, 29'd0);
        check("reset_wdata", app_wdf_data, 128'd0);
        rst = 1'b0;
        en = 1'b1;
        app_rdy = 1'b1;
        app_wdf_rdy = 1'b1;

        // single read
        base_rd = n_rd_acc;
        push_rd(32'h0000_0100);
        tick();
        check("rd1_cmd", {app_en, app_cmd, app_addr}, {1'b1, 3'b001, 29'h100});
        tick();
        check("rd1_en_drop", app_en, 1'b0);
        check("rd1_outstanding", outstanding, 8'd1);
        check("rd1_accepts", n_rd_acc - base_rd, 1);
        app_rd_data_valid = 1'b1;
        tick();
        check("rd1_returned", {outstanding, err_underflow}, 9'd0);

        // single write with data and command backpressure
        base_wr = n_wr_acc;
        push_wr(32'h0000_0200, 128'hDEAD_0000_1111_2222_3333_4444_5555_BEEF);
        app_rdy = 1'b0;
        app_wdf_rdy = 1'b0;
        wc = 0;
        ec = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (app_wdf_wren) wc++;
            if (app_en) ec++;
            app_wdf_rdy = app_wdf_wren && (wc == 4);
            app_rdy = app_en && (ec == 3);
        end
        check("wr1_wren_cycles", wc, 4);
        check("wr1_en_cycles", ec, 3);
        check("wr1_pops", n_wr_acc - base_wr, 1);
        app_rdy = 1'b1;
        app_wdf_rdy = 1'b1;

        // table-driven grant decisions
        auto_ret = 1'b1;
        foreach (vecs[i]) begin
            en = vecs[i].en;
            rd_out_full = vecs[i].rd_full;
            if (vecs[i].rd_ne) push_rd(vecs[i].addr);
            if (vecs[i].wr_ne) push_wr(vecs[i].addr ^ 32'h0000_0040, vecs[i].data);
            tick();
            obs = (app_en && (app_cmd == 3'b001)) ? G_RD : (app_wdf_wren ? G_WR : G_NONE);
            check($sformatf("grant_vec%0d", i), obs, vecs[i].exp_grant);
            en = 1'b1;
            rd_out_full = 1'b0;
            wait_idle($sformatf("drain_vec%0d", i));
        end

        // sustained contention: alternating runs of BURST_LIMIT grants
        glog.delete();
        for (int i = 0; i < 20; i++) begin
            push_rd(32'h0001_0000 + 32'(i * 64));
            push_wr(32'h8002_0000 + 32'(i * 64), {4{32'(i) ^ 32'hA5A5_0000}});
        end
        wait_idle("burst_drain");
        check("burst_total", glog.size(), 40);
        cur = 1;
        for (int i = 1; i < glog.size(); i++) begin
            if (glog[i] == glog[i - 1]) cur++;
            else begin
                runs.push_back(cur);
                cur = 1;
            end
        end
        runs.push_back(cur);
        check("burst_run_count_ge8", runs.size() >= 8, 1'b1);
        for (int i = 1; i < runs.size() - 1; i++) check($sformatf("burst_run%0d", i), runs[i], BL);
        check("burst_first_run_le", runs[0] <= BL, 1'b1);
        check("burst_last_run_le", runs[runs.size() - 1] <= BL, 1'b1);

        // outstanding limit and read-data backpressure
        auto_ret = 1'b0;
        base_rd = n_rd_acc;
        base_wr = n_wr_acc;
        for (int i = 0; i < 4; i++) push_rd(32'h0003_0000 + 32'(i * 64));
        for (int i = 0; i < 3; i++) push_wr(32'h0004_0000 + 32'(i * 64), {4{32'hC0DE_0000 + 32'(i)}});
        for (int i = 0; i < 30; i++) tick();
        check("max_reads_issued", n_rd_acc - base_rd, 2);
        check("max_writes_done", n_wr_acc - base_wr, 3);
        check("max_outstanding", outstanding, 8'd2);
        app_rd_data_valid = 1'b1;
        tick();
        for (int i = 0; i < 10; i++) tick();
        check("max_one_more", n_rd_acc - base_rd, 3);
        check("max_outstanding2", outstanding, 8'd2);
        rd_out_full = 1'b1;
        app_rd_data_valid = 1'b1;
        tick();
        app_rd_data_valid = 1'b1;
        tick();
        for (int i = 0; i < 10; i++) tick();
        check("full_blocks_reads", n_rd_acc - base_rd, 3);
        check("full_outstanding0", outstanding, 8'd0);
        rd_out_full = 1'b0;
        auto_ret = 1'b1;
        wait_idle("max_drain");
        check("max_final_reads", n_rd_acc - base_rd, 4);

        // same-cycle accept and return, then underflow
        auto_ret = 1'b0;
        push_rd(32'h0005_0000);
        tick();
        tick();
        check("same_pre", outstanding, 8'd1);
        push_rd(32'h0005_0040);
        tick();
        check("same_granted", app_en, 1'b1);
        app_rd_data_valid = 1'b1;
        tick();
        check("same_cycle_count", {outstanding, err_underflow}, {8'd1, 1'b0});
        app_rd_data_valid = 1'b1;
        tick();
        check("same_return", outstanding, 8'd0);
        app_rd_data_valid = 1'b1;
        tick();
        check("underflow", {outstanding, err_underflow}, {8'd0, 1'b1});
        tick();
        check("underflow_sticky", err_underflow, 1'b1);
        auto_ret = 1'b1;

        // reset in WR_CMD with the MIG stalled
        base_wr = n_wr_acc;
        app_rdy = 1'b0;
        push_wr(32'h0006_0000, 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210);
        tick();
        tick();
        check("wrcmd_reached", {app_en, app_cmd, app_wdf_wren}, {1'b1, 3'b000, 1'b0});
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst_mid_ctrl", {app_en, app_wdf_wren, app_wdf_end, app_cmd, outstanding, busy, err_underflow}, 16'd0);
        check("rst_mid_addr", app_addr, 29'd0);
        check("rst_mid_nopop", n_wr_acc - base_wr, 0);
        app_rdy = 1'b1;
        wait_idle("rst_replay");
        check("rst_replay_write", n_wr_acc - base_wr, 1);

        // en low holds off grants
        en = 1'b0;
        push_rd(32'h0007_0000);
        push_wr(32'h0007_0040, 128'h5A);
        active = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (app_en || app_wdf_wren) active++;
        end
        check("en_low_no_grant", active, 0);
        en = 1'b1;
        wait_idle("en_drain");
        check("scoreboard_empty", exp_rd_q.size() + exp_wr_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
